// File: rtl/matrix_stream_buffer_if.sv
// Load, stream-out and random-access read signals of the matrix stream buffer.
// The master modport is the producer/consumer side and the slave modport is the buffer side.
interface matrix_stream_buffer_if #(
  parameter int DW = 8,
  parameter int CW = 3
);
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          start;
  logic          transpose;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [DW-1:0] rd_row;
  logic [DW-1:0] rd_col;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] fill_count;
  logic          full;

  modport master (
    output clear, in_valid, in_data, start, transpose, out_ready, rd_row, rd_col,
    input  in_ready, out_valid, out_data, out_last, rd_data, fill_count, full
  );

  modport slave (
    input  clear, in_valid, in_data, start, transpose, out_ready, rd_row, rd_col,
    output in_ready, out_valid, out_data, out_last, rd_data, fill_count, full
  );
endinterface

// File: rtl/matrix_stream_buffer.sv
// M x N register matrix loaded row-major and streamed out row- or column-major,
// with a combinational random-access read port.
module matrix_stream_buffer #(
  parameter int M  = 2,
  parameter int N  = 2,
  parameter int DW = 8,
  localparam int CW = $clog2(M*N+1)
) (
  input logic              clk,
  input logic              rst,
  matrix_stream_buffer_if.slave bus
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = (DW > 32) ? DW : 32;

  typedef enum logic [1:0] {EMPTY, LOAD, FULL, READ} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [DW-1:0]  mem [M][N];
  logic [RW-1:0]  wr_row;
  logic [NW-1:0]  wr_col;
  logic [RW-1:0]  rd_ptr_row;
  logic [NW-1:0]  rd_ptr_col;
  logic [CW-1:0]  fill_count;
  logic           xpose;
  logic           load_fire;
  logic           out_fire;
  logic           fill_last;
  logic           at_last;
  logic [AW-1:0]  rd_row_w;
  logic [AW-1:0]  rd_col_w;

  assign rd_row_w  = AW'(bus.rd_row);
  assign rd_col_w  = AW'(bus.rd_col);
  assign fill_last = (fill_count == CW'(M*N-1));
  // Both readout orders finish on the bottom-right element.
  assign at_last   = (rd_ptr_row == RW'(M-1)) && (rd_ptr_col == NW'(N-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_last   = 1'b0;
    bus.full       = 1'b0;
    load_fire      = 1'b0;
    out_fire       = 1'b0;

    case (state)
      EMPTY, LOAD: bus.in_ready = rst;
      FULL:        bus.full     = 1'b1;
      READ: begin
        bus.out_valid = 1'b1;
        bus.out_last  = at_last;
      end
      default: ;
    endcase

    load_fire = bus.in_valid && bus.in_ready && !bus.clear;
    out_fire  = bus.out_valid && bus.out_ready && !bus.clear;

    if (bus.clear) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY, LOAD: if (load_fire) state_nxt = fill_last ? FULL : LOAD;
        FULL:        if (bus.start) state_nxt = READ;
        READ:        if (out_fire && at_last) state_nxt = EMPTY;
        default:     state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          mem[r][c] <= '0;
      wr_row     <= '0;
      wr_col     <= '0;
      rd_ptr_row <= '0;
      rd_ptr_col <= '0;
      fill_count <= '0;
      xpose      <= 1'b0;
    end else if (bus.clear) begin
      wr_row     <= '0;
      wr_col     <= '0;
      rd_ptr_row <= '0;
      rd_ptr_col <= '0;
      fill_count <= '0;
    end else begin
      if (load_fire) begin
        for (int r = 0; r < M; r++)
          for (int c = 0; c < N; c++)
            if (wr_row == RW'(r) && wr_col == NW'(c))
              mem[r][c] <= bus.in_data;
        fill_count <= fill_count + CW'(1);
        if (fill_last) begin
          wr_row <= '0;
          wr_col <= '0;
        end else if (wr_col == NW'(N-1)) begin
          wr_col <= '0;
          wr_row <= wr_row + RW'(1);
        end else begin
          wr_col <= wr_col + NW'(1);
        end
      end

      if (state == FULL && bus.start)
        xpose <= bus.transpose;

      // Readout order is fixed by the transpose bit captured at start.
      if (out_fire) begin
        if (at_last) begin
          rd_ptr_row <= '0;
          rd_ptr_col <= '0;
          fill_count <= '0;
        end else if (!xpose) begin
          if (rd_ptr_col == NW'(N-1)) begin
            rd_ptr_col <= '0;
            rd_ptr_row <= rd_ptr_row + RW'(1);
          end else begin
            rd_ptr_col <= rd_ptr_col + NW'(1);
          end
        end else begin
          if (rd_ptr_row == RW'(M-1)) begin
            rd_ptr_row <= '0;
            rd_ptr_col <= rd_ptr_col + NW'(1);
          end else begin
            rd_ptr_row <= rd_ptr_row + RW'(1);
          end
        end
      end
    end
  end

  always_comb begin
    bus.out_data = '0;
    bus.rd_data  = '0;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) begin
        if (state == READ && rd_ptr_row == RW'(r) && rd_ptr_col == NW'(c))
          bus.out_data = mem[r][c];
        // Out-of-range addresses match no element and read as zero.
        if (rd_row_w == AW'(r) && rd_col_w == AW'(c))
          bus.rd_data = mem[r][c];
      end
    end
  end

  assign bus.fill_count = fill_count;

endmodule

// File: tb/tb_matrix_stream_buffer.sv
// Scoreboard bench for matrix_stream_buffer with M=2, N=3, DW=8.
module tb_matrix_stream_buffer;
  localparam int M  = 2;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int CW = $clog2(M*N+1);

  logic clk = 1'b0;
  logic rst = 1'b0;

  matrix_stream_buffer_if #(.DW(DW), .CW(CW)) bus ();
  matrix_stream_buffer #(.M(M), .N(N), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    q.push_back(e);
  endtask

  task automatic rd_chk(input string name, input int r, input int c, input logic [DW-1:0] exp);
    bus.rd_row = DW'(r);
    bus.rd_col = DW'(c);
    #1;
    chk(name, bus.rd_data, exp);
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(base + i);
      #1;
      chk("in_ready_during_load", bus.in_ready, 1);
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic start_read(input logic t);
    bus.start     = 1'b1;
    bus.transpose = t;
    step();
    bus.start     = 1'b0;
    bus.transpose = ~t;
  endtask

  task automatic drain(input logic toggle);
    int cyc;
    for (cyc = 0; cyc < 40 && q.size() > 0; cyc++) begin
      bus.out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      step();
    end
    bus.out_ready = 1'b0;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", q.size());
      q.delete();
    end
  endtask

  task automatic chk_empty_state(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_fill_count"}, bus.fill_count, 0);
    chk({tag, "_full"}, bus.full, 0);
  endtask

  // Monitor: every presented element is compared; it is consumed only on a transfer.
  always @(negedge clk) begin
    if (rst && bus.out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_unexpected actual=%0d expected=none", bus.out_data);
      end else begin
        chk("stream_data", bus.out_data, q[0].data);
        chk("stream_last", bus.out_last, q[0].last);
        if (bus.out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.start     = 1'b0;
    bus.transpose = 1'b0;
    bus.out_ready = 1'b0;
    bus.rd_row    = '0;
    bus.rd_col    = '0;

    #12;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_fill_count", bus.fill_count, 0);
    rd_chk("rst_rd_data", 0, 0, 0);
    step();
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Row-major load then row-major readout.
    load(6, 1);
    chk("load_full", bus.full, 1);
    chk("load_in_ready", bus.in_ready, 0);
    chk("load_fill_count", bus.fill_count, 6);
    chk("load_out_valid", bus.out_valid, 0);
    rd_chk("load_rd_1_2", 1, 2, 6);
    for (int i = 1; i <= 6; i++) push(DW'(i), i == 6);
    start_read(1'b0);
    drain(1'b0);
    chk_empty_state("row_major_end");

    // Column-major readout with a stalling consumer.
    load(6, 1);
    push(1, 0); push(4, 0); push(2, 0); push(5, 0); push(3, 0); push(6, 1);
    start_read(1'b1);
    drain(1'b1);
    chk_empty_state("col_major_end");

    // Clear beats a simultaneous load beat.
    load(3, 11);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd99;
    bus.clear    = 1'b1;
    step();
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    chk("clear_fill_count", bus.fill_count, 0);
    chk("clear_in_ready", bus.in_ready, 1);
    rd_chk("clear_rd_0_0", 0, 0, 11);
    rd_chk("clear_rd_0_2", 0, 2, 13);
    rd_chk("clear_rd_1_0_unwritten", 1, 0, 4);

    // Start is ignored outside FULL; out-of-range reads are zero.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_empty_state("start_in_empty");
    rd_chk("oor_rd_2_0", 2, 0, 0);
    rd_chk("oor_rd_0_3", 0, 3, 0);
    rd_chk("oor_rd_255_255", 255, 255, 0);
    load(2, 21);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_in_load_out_valid", bus.out_valid, 0);
    chk("start_in_load_fill_count", bus.fill_count, 2);
    chk("start_in_load_in_ready", bus.in_ready, 1);
    load(4, 23);
    chk("resume_full", bus.full, 1);
    for (int i = 0; i < 6; i++) push(DW'(21 + i), i == 5);
    start_read(1'b0);
    drain(1'b0);
    chk_empty_state("resume_end");

    // Reset while element 4 is presented.
    load(6, 1);
    push(1, 0); push(2, 0); push(3, 0); push(4, 0);
    start_read(1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.out_ready = 1'b1;
      step();
    end
    bus.out_ready = 1'b0;
    step();
    chk("pre_reset_pending", q.size(), 1);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_last", bus.out_last, 0);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_full", bus.full, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        rd_chk("midrst_rd_data", r, c, 0);
    q.delete();
    step();
    rst = 1'b1;
    #1;
    chk_empty_state("after_midrst");

    step();
    chk("queue_empty_at_end", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
